// File: rtl/fp_align_seq.sv
// fp_align_seq: sequential exponent-alignment controller for the FP add/sub path.
// Orders two single-precision operands by exponent, then right-shifts the
// smaller significand SHIFT_STEP bits per cycle until both share one exponent.
// Optional feature macro: ALIGN_STICKY_EN (adds the sticky output and its logic;
// when undefined the shifted-out bits are simply truncated).
module fp_align_seq #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_out,
  output logic [23:0] man_big,
  output logic [23:0] man_small,
  output logic        sign_big,
  output logic        sign_small,
  output logic        swapped,
`ifdef ALIGN_STICKY_EN
  output logic        sticky,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP_W = 5'(SHIFT_STEP);

  state_t      state_reg, state_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [7:0]  exp_reg, exp_next;
  logic [23:0] man_big_reg, man_big_next;
  logic [23:0] man_small_reg, man_small_next;
  logic        sign_big_reg, sign_big_next;
  logic        sign_small_reg, sign_small_next;
  logic        swapped_reg, swapped_next;
  logic [4:0]  rem_reg, rem_next;
`ifdef ALIGN_STICKY_EN
  logic        sticky_reg, sticky_next;
  logic [23:0] out_mask;
`endif

  // Operand decode from the captured pair; the exponent field is used as-is.
  logic [7:0]  exp_a, exp_b;
  logic [23:0] sig_a, sig_b;
  logic [8:0]  diff;
  logic        a_is_big;
  logic [7:0]  d;
  logic [4:0]  step_s;

  assign exp_a    = a_reg[30:23];
  assign exp_b    = b_reg[30:23];
  assign sig_a    = {exp_a != 8'd0, a_reg[22:0]};
  assign sig_b    = {exp_b != 8'd0, b_reg[22:0]};
  assign diff     = {1'b0, exp_a} - {1'b0, exp_b};
  assign a_is_big = ~diff[8];                       // tie keeps A as the big operand
  assign d        = a_is_big ? diff[7:0] : (~diff[7:0] + 8'd1);
  assign step_s   = (rem_reg < STEP_W) ? rem_reg : STEP_W;
`ifdef ALIGN_STICKY_EN
  assign out_mask = (24'd1 << step_s) - 24'd1;     // bits leaving man_small this cycle
`endif

  // Next-state and datapath update; every target defaults to its held value.
  always_comb begin
    state_next      = state_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    exp_next        = exp_reg;
    man_big_next    = man_big_reg;
    man_small_next  = man_small_reg;
    sign_big_next   = sign_big_reg;
    sign_small_next = sign_small_reg;
    swapped_next    = swapped_reg;
    rem_next        = rem_reg;
`ifdef ALIGN_STICKY_EN
    sticky_next     = sticky_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = a;
          b_next     = b;
`ifdef ALIGN_STICKY_EN
          sticky_next = 1'b0;
`endif
          state_next = CMP;
        end
      end
      CMP: begin
        swapped_next    = ~a_is_big;
        exp_next        = a_is_big ? exp_a : exp_b;
        man_big_next    = a_is_big ? sig_a : sig_b;
        sign_big_next   = a_is_big ? a_reg[31] : b_reg[31];
        sign_small_next = a_is_big ? b_reg[31] : a_reg[31];
        man_small_next  = a_is_big ? sig_b : sig_a;
        if (d == 8'd0) begin
          state_next = DONE;
        end else if (d >= 8'd24) begin
          // Everything falls off the end: skip the shifter entirely.
          man_small_next = 24'd0;
`ifdef ALIGN_STICKY_EN
          sticky_next    = |(a_is_big ? sig_b : sig_a);
`endif
          state_next     = DONE;
        end else begin
          rem_next   = d[4:0];
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        man_small_next = man_small_reg >> step_s;
`ifdef ALIGN_STICKY_EN
        sticky_next    = sticky_reg | (|(man_small_reg & out_mask));
`endif
        rem_next       = rem_reg - step_s;
        if (rem_reg == step_s) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      a_reg          <= 32'd0;
      b_reg          <= 32'd0;
      exp_reg        <= 8'd0;
      man_big_reg    <= 24'd0;
      man_small_reg  <= 24'd0;
      sign_big_reg   <= 1'b0;
      sign_small_reg <= 1'b0;
      swapped_reg    <= 1'b0;
      rem_reg        <= 5'd0;
`ifdef ALIGN_STICKY_EN
      sticky_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      exp_reg        <= exp_next;
      man_big_reg    <= man_big_next;
      man_small_reg  <= man_small_next;
      sign_big_reg   <= sign_big_next;
      sign_small_reg <= sign_small_next;
      swapped_reg    <= swapped_next;
      rem_reg        <= rem_next;
`ifdef ALIGN_STICKY_EN
      sticky_reg     <= sticky_next;
`endif
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);
  assign exp_out    = exp_reg;
  assign man_big    = man_big_reg;
  assign man_small  = man_small_reg;
  assign sign_big   = sign_big_reg;
  assign sign_small = sign_small_reg;
  assign swapped    = swapped_reg;
`ifdef ALIGN_STICKY_EN
  assign sticky     = sticky_reg;
`endif

endmodule
